// File: rtl/capture_pkg.sv
// Shared types and constants for the capture write-side sequencer.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } capture_state_t;

  localparam logic EDGE_FALL = 1'b0;
  localparam logic EDGE_RISE = 1'b1;

endpackage

// File: rtl/capture_ctrl_if.sv
// Sample/config/FIFO-write bundle between the ADC front end, host config and capture_ctrl.
interface capture_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 10
);
  import capture_pkg::*;

  // Handshake: sample_valid_i qualifies sample_i for exactly the cycle it is high; there is
  // no ready/backpressure, so a write due while fifo_full_i is high is dropped and flagged.
  logic                  arm_i;
  logic                  abort_i;
  logic [DATA_WIDTH-1:0] sample_i;
  logic                  sample_valid_i;
  logic [DATA_WIDTH-1:0] trig_level_i;
  logic                  trig_rising_i;
  logic [CNT_WIDTH-1:0]  pre_len_i;
  logic [CNT_WIDTH-1:0]  post_len_i;
  logic                  fifo_full_i;
  logic                  fifo_wr_en_o;
  logic [DATA_WIDTH-1:0] fifo_wr_data_o;
  logic                  busy_o;
  logic                  triggered_o;
  logic                  done_o;
  logic                  overflow_o;
  capture_state_t        state_o;

  modport slave (
    input  arm_i, abort_i, sample_i, sample_valid_i, trig_level_i, trig_rising_i,
           pre_len_i, post_len_i, fifo_full_i,
    output fifo_wr_en_o, fifo_wr_data_o, busy_o, triggered_o, done_o, overflow_o, state_o
  );

  modport master (
    output arm_i, abort_i, sample_i, sample_valid_i, trig_level_i, trig_rising_i,
           pre_len_i, post_len_i, fifo_full_i,
    input  fifo_wr_en_o, fifo_wr_data_o, busy_o, triggered_o, done_o, overflow_o, state_o
  );

endinterface

// File: rtl/capture_ctrl_trig_detect.sv
// Level-crossing trigger detector: remembers the last tracked valid sample and flags a crossing.
module trig_detect
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_track,
  input  logic                  i_enable,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic [DATA_WIDTH-1:0] i_level,
  input  logic                  i_rising,
  output logic                  o_hit
);

  logic [DATA_WIDTH-1:0] r_prev;
  logic                  r_prev_valid;
  logic                  w_rise_cross;
  logic                  w_fall_cross;

  // Clear wins so the sample seen on the arm cycle never becomes "prev".
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
    end else if (i_clear) begin
      r_prev_valid <= 1'b0;
    end else if (i_track && i_valid) begin
      r_prev       <= i_sample;
      r_prev_valid <= 1'b1;
    end
  end

  assign w_rise_cross = (r_prev < i_level) && (i_sample >= i_level);
  assign w_fall_cross = (r_prev > i_level) && (i_sample <= i_level);

  assign o_hit = i_enable && i_valid && r_prev_valid &&
                 ((i_rising == EDGE_RISE) ? w_rise_cross : w_fall_cross);

endmodule

// File: rtl/capture_ctrl.sv
// Write-side sequencer for the sample FIFO: pre-trigger, trigger and post-trigger sample pushes.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 10
) (
  input  logic           clk_i,
  input  logic           rst_i,
  capture_ctrl_if.slave  bus
);

  capture_state_t        r_state;
  logic [CNT_WIDTH-1:0]  r_pre_len;
  logic [CNT_WIDTH-1:0]  r_post_len;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_level;
  logic                  r_rising;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_triggered;
  logic                  r_done;
  logic                  r_overflow;

  logic                  w_arm_accept;
  logic                  w_abort;
  logic                  w_track;
  logic                  w_trig_en;
  logic                  w_hit;
  logic                  w_write_due;
  logic [CNT_WIDTH-1:0]  w_cnt_next;

  assign w_arm_accept = (r_state == IDLE) && bus.arm_i && !bus.abort_i;
  assign w_abort      = (r_state != IDLE) && bus.abort_i;
  assign w_track      = (r_state == PRE) || (r_state == WAIT_TRIG);
  assign w_trig_en    = (r_state == WAIT_TRIG) && !bus.abort_i;
  assign w_cnt_next   = r_cnt + 1'b1;

  trig_detect #(.DATA_WIDTH(DATA_WIDTH)) u_trig (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_clear  (w_arm_accept),
    .i_track  (w_track),
    .i_enable (w_trig_en),
    .i_valid  (bus.sample_valid_i),
    .i_sample (bus.sample_i),
    .i_level  (r_level),
    .i_rising (r_rising),
    .o_hit    (w_hit)
  );

  always_comb begin
    w_write_due = 1'b0;
    if (!w_abort && bus.sample_valid_i) begin
      unique case (r_state)
        PRE, POST: w_write_due = 1'b1;
        WAIT_TRIG: w_write_due = w_hit;
        default:   w_write_due = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_pre_len   <= '0;
      r_post_len  <= '0;
      r_cnt       <= '0;
      r_level     <= '0;
      r_rising    <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      // A full FIFO drops the write but the counters below still advance.
      if (w_write_due) begin
        r_wr_data <= bus.sample_i;
        if (bus.fifo_full_i) r_overflow <= 1'b1;
        else                 r_wr_en    <= 1'b1;
      end
      if (w_abort) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_arm_accept) begin
              r_pre_len   <= bus.pre_len_i;
              r_post_len  <= bus.post_len_i;
              r_level     <= bus.trig_level_i;
              r_rising    <= bus.trig_rising_i;
              r_overflow  <= 1'b0;
              r_triggered <= 1'b0;
              r_cnt       <= '0;
              r_state     <= (bus.pre_len_i != '0) ? PRE : WAIT_TRIG;
            end
          end
          PRE: begin
            if (bus.sample_valid_i) begin
              if (w_cnt_next == r_pre_len) begin
                r_cnt   <= '0;
                r_state <= WAIT_TRIG;
              end else begin
                r_cnt <= w_cnt_next;
              end
            end
          end
          WAIT_TRIG: begin
            if (w_hit) begin
              r_triggered <= 1'b1;
              r_cnt       <= '0;
              if (r_post_len != '0) begin
                r_state <= POST;
              end else begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end
          end
          POST: begin
            if (bus.sample_valid_i) begin
              if (w_cnt_next == r_post_len) begin
                r_cnt   <= '0;
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_cnt <= w_cnt_next;
              end
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.fifo_wr_en_o   = r_wr_en;
  assign bus.fifo_wr_data_o = r_wr_data;
  assign bus.busy_o         = (r_state != IDLE);
  assign bus.triggered_o    = r_triggered;
  assign bus.done_o         = r_done;
  assign bus.overflow_o     = r_overflow;
  assign bus.state_o        = r_state;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: directed vector table, corner sequences, random captures.
module tb_capture_ctrl;
  import capture_pkg::*;

  localparam int DW = 8;
  localparam int CW = 10;
  localparam int MAXN = 64;

  logic clk_i = 1'b0;
  logic rst_i;

  capture_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  capture_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  logic [DW-1:0] got_q[$];
  int            done_cnt;
  always @(negedge clk_i) begin
    if (bus.fifo_wr_en_o === 1'b1) got_q.push_back(bus.fifo_wr_data_o);
    if (bus.done_o === 1'b1) done_cnt++;
  end

  // Stimulus stream and reference model results.
  int            n;
  logic          st_v[MAXN];
  logic [DW-1:0] st_s[MAXN];
  logic          st_f[MAXN];
  logic [DW-1:0] exp_q[$];
  logic          exp_ovf, exp_trig, exp_done;
  int            exp_done_at;
  int            last_done_at;

  // Capture as a list of valid samples: first pre are kept, then the first crossing
  // (needing a predecessor), then post more. Dropped if full on that sample.
  function automatic void model(input int pre, input int post, input logic [DW-1:0] lvl,
                                input logic rise);
    int k, t;
    bit found, wr, hit;
    logic [DW-1:0] prev;
    exp_q.delete();
    exp_ovf = 0; exp_trig = 0; exp_done = 0; exp_done_at = -1;
    k = 0; t = 0; found = 0; prev = '0;
    for (int c = 0; c < n; c++) begin
      if (st_v[c]) begin
        wr = 0;
        if (k < pre) begin
          wr = 1;
        end else if (!found) begin
          hit = (k > 0) && (rise ? (prev < lvl && st_s[c] >= lvl) : (prev > lvl && st_s[c] <= lvl));
          if (hit) begin
            found = 1; t = k; wr = 1; exp_trig = 1;
            if (post == 0) exp_done = 1;
          end
        end else if (k <= t + post) begin
          wr = 1;
          if (k == t + post) exp_done = 1;
        end
        if (wr) begin
          if (st_f[c]) exp_ovf = 1;
          else exp_q.push_back(st_s[c]);
        end
        prev = st_s[c];
        k++;
        if (exp_done) begin
          exp_done_at = k;
          break;
        end
      end
    end
  endfunction

  task automatic idle_inputs();
    bus.arm_i = 0; bus.abort_i = 0; bus.sample_valid_i = 0; bus.sample_i = '0; bus.fifo_full_i = 0;
  endtask

  task automatic set_cfg(input int pre, input int post, input logic [DW-1:0] lvl, input logic rise);
    bus.pre_len_i = CW'(pre); bus.post_len_i = CW'(post); bus.trig_level_i = lvl; bus.trig_rising_i = rise;
  endtask

  task automatic arm_now(input int pre, input int post, input logic [DW-1:0] lvl, input logic rise);
    set_cfg(pre, post, lvl, rise);
    bus.arm_i = 1;
    @(negedge clk_i);
    bus.arm_i = 0;
  endtask

  task automatic drive_sample(input logic [DW-1:0] s, input logic full);
    bus.sample_valid_i = 1; bus.sample_i = s; bus.fifo_full_i = full;
    @(negedge clk_i);
    bus.sample_valid_i = 0; bus.fifo_full_i = 0;
  endtask

  // Runs the loaded stream as one capture, scrambling config mid-capture, and scores it.
  task automatic run_capture(input int pre, input int post, input logic [DW-1:0] lvl,
                             input logic rise, input string tag);
    int nv;
    model(pre, post, lvl, rise);
    got_q.delete(); done_cnt = 0;
    arm_now(pre, post, lvl, rise);
    nv = 0; last_done_at = -1;
    for (int c = 0; c < n; c++) begin
      bus.sample_valid_i = st_v[c]; bus.sample_i = st_s[c]; bus.fifo_full_i = st_f[c];
      if ($urandom_range(0, 3) == 0)
        set_cfg($urandom_range(0, 15), $urandom_range(0, 15), DW'($urandom), 1'($urandom));
      @(negedge clk_i);
      if (st_v[c]) nv++;
      if (bus.done_o === 1'b1 && last_done_at < 0) last_done_at = nv;
    end
    idle_inputs();
    if (!exp_done) begin
      bus.abort_i = 1;
      @(negedge clk_i);
      bus.abort_i = 0;
    end
    for (int i = 0; i < 10 && bus.busy_o !== 1'b0; i++) @(negedge clk_i);
    @(negedge clk_i);
    check({tag, " busy_end"}, 32'(bus.busy_o), 32'(0));
    check({tag, " wr_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s wr_data[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, " overflow"}, 32'(bus.overflow_o), 32'(exp_ovf));
    check({tag, " triggered"}, 32'(bus.triggered_o), 32'(exp_trig));
    check({tag, " done_cnt"}, done_cnt, 32'(exp_done));
    if (exp_done) check({tag, " done_at"}, last_done_at, exp_done_at);
  endtask

  typedef struct {
    logic          arm;
    logic          ab;
    int            pre;
    int            post;
    logic [DW-1:0] lvl;
    logic          rise;
    logic          v;
    logic [DW-1:0] s;
    logic          f;
    logic          e_wr;
    logic [DW-1:0] e_d;
    logic          e_trig;
    logic          e_done;
    logic          e_busy;
  } vec_t;

  function automatic vec_t mk(input logic arm, input logic ab, input int pre, input int post,
                              input logic [DW-1:0] lvl, input logic rise, input logic v,
                              input logic [DW-1:0] s, input logic e_wr, input logic [DW-1:0] e_d,
                              input logic e_trig, input logic e_done, input logic e_busy);
    vec_t r;
    r.arm = arm; r.ab = ab; r.pre = pre; r.post = post; r.lvl = lvl; r.rise = rise;
    r.v = v; r.s = s; r.f = 1'b0; r.e_wr = e_wr; r.e_d = e_d;
    r.e_trig = e_trig; r.e_done = e_done; r.e_busy = e_busy;
    return r;
  endfunction

  vec_t tbl[15];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Rising 0x80, pre=3 post=2, then falling 0x40 with pre=0 post=0, then arm+abort.
    tbl[0]  = mk(1, 0, 3, 2, 8'h80, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    tbl[1]  = mk(0, 0, 3, 2, 8'h80, 1, 1, 8'd10, 1, 8'd10, 0, 0, 1);
    tbl[2]  = mk(0, 0, 3, 2, 8'h80, 1, 1, 8'd20, 1, 8'd20, 0, 0, 1);
    tbl[3]  = mk(0, 0, 3, 2, 8'h80, 1, 1, 8'd30, 1, 8'd30, 0, 0, 1);
    tbl[4]  = mk(0, 0, 3, 2, 8'h80, 1, 1, 8'd40, 0, 8'h00, 0, 0, 1);
    tbl[5]  = mk(0, 0, 3, 2, 8'h80, 1, 1, 8'h90, 1, 8'h90, 1, 0, 1);
    tbl[6]  = mk(0, 0, 3, 2, 8'h80, 1, 1, 8'd50, 1, 8'd50, 1, 0, 1);
    tbl[7]  = mk(0, 0, 3, 2, 8'h80, 1, 1, 8'd60, 1, 8'd60, 1, 1, 1);
    tbl[8]  = mk(0, 0, 3, 2, 8'h80, 1, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 8'h40, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 8'h40, 0, 1, 8'h30, 0, 8'h00, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 8'h40, 0, 1, 8'h50, 0, 8'h00, 0, 0, 1);
    tbl[12] = mk(0, 0, 0, 0, 8'h40, 0, 1, 8'h40, 1, 8'h40, 1, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 8'h40, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    tbl[14] = mk(1, 1, 2, 2, 8'h10, 1, 0, 8'h00, 0, 8'h00, 1, 0, 0);

    // Clock/reset
    idle_inputs();
    set_cfg(0, 0, 8'h00, 0);
    bus.arm_i = 1;
    rst_i = 1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
    bus.arm_i = 0;
    check("reset state", 32'(bus.state_o), 32'(IDLE));
    check("reset wr_en", 32'(bus.fifo_wr_en_o), 0);
    check("reset wr_data", 32'(bus.fifo_wr_data_o), 0);
    check("reset busy", 32'(bus.busy_o), 0);
    check("reset triggered", 32'(bus.triggered_o), 0);
    check("reset done", 32'(bus.done_o), 0);
    check("reset overflow", 32'(bus.overflow_o), 0);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      bus.arm_i = tbl[i].arm;
      bus.abort_i = tbl[i].ab;
      if (tbl[i].arm) set_cfg(tbl[i].pre, tbl[i].post, tbl[i].lvl, tbl[i].rise);
      bus.sample_valid_i = tbl[i].v; bus.sample_i = tbl[i].s; bus.fifo_full_i = tbl[i].f;
      @(negedge clk_i);
      check($sformatf("vec%0d wr_en", i), 32'(bus.fifo_wr_en_o), 32'(tbl[i].e_wr));
      if (tbl[i].e_wr) check($sformatf("vec%0d wr_data", i), 32'(bus.fifo_wr_data_o), 32'(tbl[i].e_d));
      check($sformatf("vec%0d triggered", i), 32'(bus.triggered_o), 32'(tbl[i].e_trig));
      check($sformatf("vec%0d done", i), 32'(bus.done_o), 32'(tbl[i].e_done));
      check($sformatf("vec%0d busy", i), 32'(bus.busy_o), 32'(tbl[i].e_busy));
    end
    idle_inputs();
    @(negedge clk_i);

    // FIFO full on PRE samples 2 and 3: two drops, capture still ends on the 9th sample.
    n = 11;
    for (int i = 0; i < n; i++) begin st_v[i] = (i < 9); st_f[i] = (i == 1 || i == 2); end
    st_s[0] = 8'h10; st_s[1] = 8'h20; st_s[2] = 8'h30; st_s[3] = 8'h40; st_s[4] = 8'hA0;
    st_s[5] = 8'h11; st_s[6] = 8'h12; st_s[7] = 8'h13; st_s[8] = 8'h14; st_s[9] = 0; st_s[10] = 0;
    run_capture(4, 4, 8'h80, 1, "ovf");
    check("ovf writes", got_q.size(), 7);
    check("ovf done slot", last_done_at, 9);
    check("ovf held", 32'(bus.overflow_o), 1);
    arm_now(4, 4, 8'h80, 1);
    check("rearm clears overflow", 32'(bus.overflow_o), 0);
    bus.abort_i = 1;
    @(negedge clk_i);
    bus.abort_i = 0;
    check("rearm abort busy", 32'(bus.busy_o), 0);

    // Abort in POST after one of five samples; an arm while busy is ignored.
    got_q.delete(); done_cnt = 0;
    arm_now(1, 5, 8'h80, 1);
    drive_sample(8'h10, 0);
    set_cfg(7, 0, 8'h00, 0);
    bus.arm_i = 1;
    @(negedge clk_i);
    bus.arm_i = 0;
    check("arm while busy ignored", 32'(bus.state_o), 32'(WAIT_TRIG));
    drive_sample(8'h90, 0);
    check("abort seq in POST", 32'(bus.state_o), 32'(POST));
    drive_sample(8'h30, 0);
    bus.abort_i = 1; bus.sample_valid_i = 1; bus.sample_i = 8'h31;
    @(negedge clk_i);
    idle_inputs();
    check("abort state", 32'(bus.state_o), 32'(IDLE));
    check("abort busy", 32'(bus.busy_o), 0);
    check("abort no write", 32'(bus.fifo_wr_en_o), 0);
    for (int i = 0; i < 3; i++) drive_sample(DW'(8'h60 + i), 0);
    check("abort write count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("abort wr0", 32'(got_q[0]), 32'h10);
      check("abort wr1", 32'(got_q[1]), 32'h90);
      check("abort wr2", 32'(got_q[2]), 32'h30);
    end
    check("abort no done", done_cnt, 0);

    // Reset in the middle of WAIT_TRIG clears everything.
    arm_now(2, 1, 8'hF0, 1);
    drive_sample(8'h01, 1);
    drive_sample(8'h02, 0);
    set_cfg(9, 9, 8'h00, 0);
    drive_sample(8'h03, 0);
    check("pre_len change ignored", 32'(bus.state_o), 32'(WAIT_TRIG));
    check("overflow before reset", 32'(bus.overflow_o), 1);
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    check("midreset state", 32'(bus.state_o), 32'(IDLE));
    check("midreset busy", 32'(bus.busy_o), 0);
    check("midreset overflow", 32'(bus.overflow_o), 0);
    check("midreset wr_en", 32'(bus.fifo_wr_en_o), 0);
    check("midreset wr_data", 32'(bus.fifo_wr_data_o), 0);
    check("midreset triggered", 32'(bus.triggered_o), 0);
    check("midreset done", 32'(bus.done_o), 0);

    // Random captures scored against the model.
    for (int r = 0; r < 25; r++) begin
      int pre, post;
      pre = $urandom_range(0, 5);
      post = $urandom_range(0, 5);
      n = pre + post + $urandom_range(4, 30);
      for (int i = 0; i < n; i++) begin
        st_v[i] = ($urandom_range(0, 3) != 0);
        st_s[i] = DW'($urandom_range(0, 255));
        st_f[i] = ($urandom_range(0, 9) == 0);
      end
      run_capture(pre, post, DW'($urandom_range(16, 240)), 1'($urandom_range(0, 1)),
                  $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
